div_result_bcd: RTL

- Downstream stage of the 16-bit sequential divider.
- Captures the divider's quotient (Result) and remainder (Reminder) when the divider raises Ready.
- Converts both values to packed BCD with a sequential shift-add-3 (double-dabble) engine, one iteration per clock.
- Presents both BCD values together for the display/seven-segment driver, with a one-cycle done pulse.

---
 rtl/div_result_bcd.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div_result_bcd.sv
// div_result_bcd
//   Sits behind the 16-bit sequential divider. On the rising edge of the
//   divider's Ready level it captures the quotient and remainder, converts
//   both to packed BCD with a shift-add-3 (double-dabble) engine running one
//   iteration per clock, and then presents both values together with a
//   one-cycle done pulse.
//
//   Ports
//     clk          system clock, rising-edge active
//     rst          asynchronous, active-low reset
//     ready_in     divider Ready level; its rising edge starts a conversion
//     result_in    divider quotient (W bits, unsigned)
//     reminder_in  divider remainder (W bits, unsigned)
//     busy         high while a conversion is running
//     done         one-cycle pulse on the cycle q_bcd/r_bcd take new values
//     q_bcd        packed BCD quotient, digit 0 in bits [3:0]
//     r_bcd        packed BCD remainder, digit 0 in bits [3:0]
module div_result_bcd #(
  parameter int W  = 16,
  parameter int ND = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ready_in,
  input  logic [W-1:0]    result_in,
  input  logic [W-1:0]    reminder_in,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] q_bcd,
  output logic [4*ND-1:0] r_bcd
);

  localparam int BW = 4 * ND;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            ready_d;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    bin;       // binary operand being shifted out
  logic [W-1:0]    rem_op;    // remainder parked until the quotient is done
  logic [BW-1:0]   acc;       // BCD accumulator
  logic [BW-1:0]   q_hold;    // finished quotient, waiting for the remainder
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_nx;
  logic [W-1:0]    bin_nx;
  logic [BW+W-1:0] shifted;
  logic            start;
  logic            last_iter;

  // Only a rising edge of the Ready level counts; a held level starts once.
  assign start     = ready_in & ~ready_d;
  assign last_iter = (cnt == CW'(W - 1));
  assign busy      = (state != IDLE);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)     state_nx = CONV_Q;
      CONV_Q:  if (last_iter) state_nx = CONV_R;
      CONV_R:  if (last_iter) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the
  // whole {bcd, binary} pair left by one. For legal W/ND the bit shifted out
  // of the top of the accumulator is always zero.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < ND; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    shifted = {acc_adj, bin} << 1;
    acc_nx  = shifted[BW+W-1:W];
    bin_nx  = shifted[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready_d <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_d <= ready_in;   // tracks Ready even while busy
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      bin    <= '0;
      rem_op <= '0;
      acc    <= '0;
      q_hold <= '0;
      q_bcd  <= '0;
      r_bcd  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // The capture edge is not an iteration.
          if (start) begin
            bin    <= result_in;
            rem_op <= reminder_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CONV_Q: begin
          if (last_iter) begin
            q_hold <= acc_nx;
            acc    <= '0;
            bin    <= rem_op;
            cnt    <= '0;
          end else begin
            acc <= acc_nx;
            bin <= bin_nx;
            cnt <= cnt + 1'b1;
          end
        end
        CONV_R: begin
          if (last_iter) begin
            // Both outputs move together so the display never shows a
            // quotient from one division next to a remainder from another.
            q_bcd <= q_hold;
            r_bcd <= acc_nx;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            acc <= acc_nx;
            bin <= bin_nx;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
